// File: rtl/muldiv_pkg.sv
// Shared execute-stage definitions: ALU opcodes plus the multiply/divide unit's
// operation codes, FSM states and iteration count.
package muldiv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_CALC   = 2'd1,
    MD_FINISH = 2'd2
  } md_state_t;

  localparam int MD_ITERATIONS = 32;

  // Bit 0 clear marks the signed variants (MULT, DIV).
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_addsub33.sv
// Add/subtract with carry-out, shared by shift-add multiply and restoring divide.
// For subtraction cout=1 means no borrow (result non-negative).
module md_addsub33 #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] r;

  assign r    = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{W{1'b0}}, sub};
  assign s    = r[W-1:0];
  assign cout = r[W];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One result bit per cycle through a single shared adder.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(MD_ITERATIONS);
  localparam logic [CW-1:0] LAST = CW'(MD_ITERATIONS - 1);

  md_state_t        state;
  md_op_t           op_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc;     // product upper half or partial remainder
  logic [WIDTH-1:0] mq;      // multiplier or quotient
  logic             neg_lo, neg_hi;

  logic             sgn_in, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

  logic [WIDTH:0]   ax, ay, as;
  logic             asub, acout;

  logic [2*WIDTH-1:0] prod_n;
  logic [WIDTH-1:0]   mq_n, acc_n;

  assign sgn_in = md_is_signed(op);
  assign b_zero = (b == '0);
  assign abs_a  = (sgn_in && a[WIDTH-1]) ? ('0 - a) : a;
  assign abs_b  = (sgn_in && b[WIDTH-1]) ? ('0 - b) : b;

  assign prod_n = '0 - {acc, mq};
  assign mq_n   = '0 - mq;
  assign acc_n  = '0 - acc;

  // Multiply adds the multiplicand only when the multiplier LSB is set;
  // divide trial-subtracts the divisor from the left-shifted remainder.
  always_comb begin
    ax   = {1'b0, acc};
    ay   = '0;
    asub = 1'b0;
    if (op_r[1]) begin
      ax   = {acc, mq[WIDTH-1]};
      ay   = {1'b0, dvs};
      asub = 1'b1;
    end else if (mq[0]) begin
      ay   = {1'b0, dvs};
    end
  end

  md_addsub33 #(.W(WIDTH + 1)) u_addsub (
    .x    (ax),
    .y    (ay),
    .sub  (asub),
    .s    (as),
    .cout (acout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= MD_IDLE;
      op_r        <= MD_MULT;
      cnt         <= '0;
      dvs         <= '0;
      acc         <= '0;
      mq          <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_r        <= md_op_t'(op);
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            acc         <= '0;
            neg_lo      <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi      <= sgn_in & (op[1] ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
            if (op[1]) begin
              dvs <= abs_b;
              mq  <= abs_a;
            end else begin
              dvs <= abs_a;
              mq  <= abs_b;
            end
            state <= MD_CALC;
            if (op[1] && b_zero) begin
              // Result is fixed: quotient all ones, remainder is the raw dividend.
              acc         <= a;
              mq          <= '1;
              neg_lo      <= 1'b0;
              neg_hi      <= 1'b0;
              div_by_zero <= 1'b1;
              state       <= MD_FINISH;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end

        MD_CALC: begin
          cnt <= cnt + CW'(1);
          if (op_r[1]) begin
            if (acout) begin
              acc <= as[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b1};
            end else begin
              acc <= ax[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= as[WIDTH:1];
            mq  <= {as[0], mq[WIDTH-1:1]};
          end
          if (cnt == LAST) state <= MD_FINISH;
        end

        MD_FINISH: begin
          if (op_r[1]) begin
            lo <= neg_lo ? mq_n : mq;
            hi <= neg_hi ? acc_n : acc;
          end else if (neg_lo) begin
            {hi, lo} <= prod_n;
          end else begin
            {hi, lo} <= {acc, mq};
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= MD_IDLE;
        end

        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
